// File: rtl/serial_msg_transmitter.sv
// Frames a header string plus a streamed payload toward a UART transmitter.
// Optional trailing XOR checksum byte is enabled by defining SERIAL_TX_CHECKSUM_EN.
module serial_msg_transmitter #(
    parameter              START_PARTICLE_MESSAGE             = "ABCDE",
    parameter int unsigned START_PARTICLE_MESSAGE_LENGTH_BYTE = 5,
    parameter              START_MAP_MESSAGE                  = "FGHIJ",
    parameter int unsigned START_MAP_MESSAGE_LENGTH_BYTE      = 5,
    parameter int unsigned PARTICLE_MESSAGE_LENGHT            = 8,
    parameter int unsigned MAP_MESSAGE_LENGHT                 = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_particle,
    input  logic       send_map,
    input  logic [7:0] msg_in,
    input  logic       msg_in_valid,
    output logic       msg_in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam int unsigned P_W     = 8 * START_PARTICLE_MESSAGE_LENGTH_BYTE;
    localparam int unsigned M_W     = 8 * START_MAP_MESSAGE_LENGTH_BYTE;
    localparam int unsigned HDR_LEN = (START_PARTICLE_MESSAGE_LENGTH_BYTE >
                                       START_MAP_MESSAGE_LENGTH_BYTE) ?
                                      START_PARTICLE_MESSAGE_LENGTH_BYTE :
                                      START_MAP_MESSAGE_LENGTH_BYTE;
    localparam int unsigned HDR_W   = 8 * HDR_LEN;
    localparam int unsigned PAY_MAX = (PARTICLE_MESSAGE_LENGHT > MAP_MESSAGE_LENGHT) ?
                                      PARTICLE_MESSAGE_LENGHT : MAP_MESSAGE_LENGHT;
    localparam int unsigned CNT_W   = $clog2(PAY_MAX + 1);
    localparam int unsigned HC_W    = $clog2(HDR_LEN + 1);

    // Headers left-aligned so the next byte to send is always the top byte.
    localparam logic [P_W-1:0]   P_HDR   = P_W'(START_PARTICLE_MESSAGE);
    localparam logic [M_W-1:0]   M_HDR   = M_W'(START_MAP_MESSAGE);
    localparam logic [HDR_W-1:0] P_HDR_L = HDR_W'(P_HDR) << (HDR_W - P_W);
    localparam logic [HDR_W-1:0] M_HDR_L = HDR_W'(M_HDR) << (HDR_W - M_W);

`ifdef SERIAL_TX_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHeader, StPayload, StChecksum, StFlush} state_t;
`else
    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StFlush} state_t;
`endif

    state_t             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [HC_W-1:0]    hdr_left_q, hdr_left_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer;
`ifdef SERIAL_TX_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
`endif

    assign xfer     = tx_valid_q && tx_ready;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        hdr_d        = hdr_q;
        hdr_left_d   = hdr_left_q;
        cnt_d        = cnt_q;
        msg_in_ready = 1'b0;
        done         = 1'b0;
`ifdef SERIAL_TX_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (send_particle) begin
                    state_d    = StHeader;
                    tx_valid_d = 1'b1;
                    tx_data_d  = P_HDR_L[HDR_W-1 -: 8];
                    hdr_d      = P_HDR_L << 8;
                    hdr_left_d = HC_W'(START_PARTICLE_MESSAGE_LENGTH_BYTE - 1);
                    cnt_d      = CNT_W'(PARTICLE_MESSAGE_LENGHT);
`ifdef SERIAL_TX_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                end else if (send_map) begin
                    state_d    = StHeader;
                    tx_valid_d = 1'b1;
                    tx_data_d  = M_HDR_L[HDR_W-1 -: 8];
                    hdr_d      = M_HDR_L << 8;
                    hdr_left_d = HC_W'(START_MAP_MESSAGE_LENGTH_BYTE - 1);
                    cnt_d      = CNT_W'(MAP_MESSAGE_LENGHT);
`ifdef SERIAL_TX_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (hdr_left_q == '0) begin
                        state_d    = StPayload;
                        tx_valid_d = 1'b0;
                    end else begin
                        tx_data_d  = hdr_q[HDR_W-1 -: 8];
                        hdr_d      = hdr_q << 8;
                        hdr_left_d = hdr_left_q - HC_W'(1);
                    end
                end
            end
            StPayload: begin
                msg_in_ready = !tx_valid_q || tx_ready;
                if (xfer) tx_valid_d = 1'b0;
                if (msg_in_valid && msg_in_ready) begin
                    tx_data_d  = msg_in;
                    tx_valid_d = 1'b1;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
`ifdef SERIAL_TX_CHECKSUM_EN
                    xor_d = xor_q ^ msg_in;
                    if (cnt_q <= CNT_W'(1)) state_d = StChecksum;
`else
                    if (cnt_q <= CNT_W'(1)) state_d = StFlush;
`endif
                end
            end
`ifdef SERIAL_TX_CHECKSUM_EN
            // Last payload byte must leave before the checksum replaces it.
            StChecksum: begin
                if (xfer) begin
                    tx_data_d = xor_q;
                    state_d   = StFlush;
                end
            end
`endif
            StFlush: begin
                if (xfer) begin
                    done       = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            hdr_q      <= '0;
            hdr_left_q <= '0;
            cnt_q      <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            hdr_q      <= hdr_d;
            hdr_left_q <= hdr_left_d;
            cnt_q      <= cnt_d;
`ifdef SERIAL_TX_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_msg_transmitter.sv
// Directed bench for serial_msg_transmitter: table of whole frames plus reset corner cases.
module tb_serial_msg_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       send_particle = 1'b0;
    logic       send_map = 1'b0;
    logic [7:0] msg_in = 8'h00;
    logic       msg_in_valid = 1'b0;
    logic       msg_in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;

    serial_msg_transmitter dut (
        .clk          (clk),
        .reset        (reset),
        .send_particle(send_particle),
        .send_map     (send_map),
        .msg_in       (msg_in),
        .msg_in_valid (msg_in_valid),
        .msg_in_ready (msg_in_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         sp;
        bit         sm;
        bit         tgl;    // tx_ready toggles every cycle
        bit         gap;    // msg_in_valid drops every third cycle
        int         inj;    // step at which a stray send_map is pulsed, -1 for none
        logic [7:0] first;  // first header byte
        int         pay;    // payload byte count
    } vec_t;

    vec_t vecs[6];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         pay_idx = 0;
    int         stab_err = 0;
    int         done_cnt = 0;
    bit         req_p = 0, req_m = 0, tgl = 0, gap = 0;
    bit         have_hold = 0, seen_done = 0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe 1ns later, well before the rising edge.
    task automatic step();
        @(negedge clk);
        send_particle = req_p;
        send_map      = req_m;
        req_p         = 0;
        req_m         = 0;
        tx_ready      = tgl ? cyc[0] : 1'b1;
        msg_in_valid  = gap ? ((cyc % 3) != 2) : 1'b1;
        msg_in        = 8'(pay_idx + 1);
        #1;
        if (have_hold && (!tx_valid || tx_data !== hold_data)) stab_err++;
        have_hold = tx_valid && !tx_ready;
        hold_data = tx_data;
        if (tx_valid && tx_ready) got.push_back(tx_data);
        seen_done = done;
        if (done) done_cnt++;
        if (msg_in_valid && msg_in_ready) pay_idx++;
        cyc++;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] ck;
        int         steps;
        int         bad;
        got.delete();
        pay_idx   = 0;
        stab_err  = 0;
        have_hold = 0;
        tgl       = v.tgl;
        gap       = v.gap;
        req_p     = v.sp;
        req_m     = v.sm;
        step();
        check({tag, "_busy_in_idle"}, 32'(busy), 32'd0);
        steps     = 0;
        seen_done = 0;
        while (!seen_done && steps < 400) begin
            if (steps == v.inj) req_m = 1;
            step();
            steps++;
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        ck = 8'h00;
        for (int i = 0; i < 5; i++) exp_q.push_back(v.first + 8'(i));
        for (int i = 1; i <= v.pay; i++) begin
            exp_q.push_back(8'(i));
            ck = ck ^ 8'(i);
        end
`ifdef SERIAL_TX_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
        check({tag, "_transfer_count"}, 32'(got.size()), 32'(exp_q.size()));
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        end
        check({tag, "_first_bad_byte_idx"}, 32'(bad), 32'hffff_ffff);
        check({tag, "_hold_violations"}, 32'(stab_err), 32'd0);
    endtask

    initial begin
        int steps;
        bit reached;
        //          sp sm tgl gap inj first  pay
        vecs[0] = '{1, 0, 0, 0, -1, 8'h41, 8};   // basic particle frame
        vecs[1] = '{1, 1, 0, 0, -1, 8'h41, 8};   // simultaneous requests, particle wins
        vecs[2] = '{0, 1, 1, 0, -1, 8'h46, 16};  // map frame with tx_ready toggling
        vecs[3] = '{1, 0, 1, 1, -1, 8'h41, 8};   // backpressure plus payload gaps
        vecs[4] = '{0, 1, 0, 1, -1, 8'h46, 16};  // map frame with payload gaps
        vecs[5] = '{1, 0, 0, 0, 3,  8'h41, 8};   // stray send_map while busy

        step();
        step();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_msg_in_ready", 32'(msg_in_ready), 32'd0);
        reset = 1'b1;

        // Frames run back to back: each request lands in the IDLE cycle after done.
        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Abort a particle frame while payload byte 3 is on the wire.
        got.delete();
        pay_idx = 0;
        tgl     = 0;
        gap     = 0;
        req_p   = 1;
        step();
        steps   = 0;
        reached = 0;
        while (!reached && steps < 100) begin
            step();
            steps++;
            reached = tx_valid && (tx_data == 8'h03) && busy;
        end
        check("midrst_reached_byte3", 32'(reached), 32'd1);
        reset = 1'b0;
        step();
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_msg_in_ready", 32'(msg_in_ready), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        step();
        check("idle_after_rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        step();
        check("no_resume_tx_valid", 32'(tx_valid), 32'd0);
        run_frame(vecs[0], "after_rst");

        check("done_pulse_total", 32'(done_cnt), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
